// File: rtl/fp8_dot_if.sv
// Operand stream into the FP8 dot-product sequencer: one operand pair per handshake.
interface fp8_dot_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/fp8_dot_sequencer.sv
// Job sequencer for one FP8 (E4M3) dot product: streams operand pairs through an external
// multiplier and adder, accumulates the products and pulses done with the final result.
//
// state | meaning
// IDLE  | waiting for start; result holds the previous job's value
// RUN   | accepting operand pairs until len_r handshakes have occurred
// DRAIN | no new pairs; waiting for the last product to reach the accumulator
// DONE  | done pulse; result valid
module fp8_dot_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    fp8_dot_if.slave         src,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [7:0]       mul_product,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [7:0]       add_sum,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_r;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [7:0]       prod_r;
    logic [7:0]       acc;
    logic             s1;
    logic             s2;
    logic             in_ready_r;
    logic             hs;

    assign hs           = src.in_valid & in_ready_r;
    assign src.in_ready = in_ready_r;
    assign mul_a        = op_a;
    assign mul_b        = op_b;
    assign add_a        = acc;
    assign add_b        = prod_r;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            len_r      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            prod_r     <= '0;
            acc        <= '0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            in_ready_r <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            // Pipeline advances in every state; the FSM below only injects and clears.
            s2   <= s1;
            s1   <= 1'b0;
            done <= 1'b0;
            if (s1) prod_r <= mul_product;
            if (s2) acc <= add_sum;

            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (len == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state      <= RUN;
                            cnt        <= '0;
                            len_r      <= len;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        op_a <= src.in_a;
                        op_b <= src.in_b;
                        s1   <= 1'b1;
                        cnt  <= cnt + LEN_W'(1);
                        if (cnt == len_r - LEN_W'(1)) begin
                            in_ready_r <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Final accumulate happens on this edge, so capture the adder output directly.
                    if (!s1 && s2) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= add_sum;
                    end
                end
                DONE: begin
                    result <= acc;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_dot_sequencer.sv
// Randomized bench for fp8_dot_sequencer: models the external FP8 multiplier/adder and
// predicts handshakes, done timing and results cycle by cycle.
module tb_fp8_dot_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] mul_a, mul_b, mul_product;
    logic [7:0] add_a, add_b, add_sum;
    logic       busy, done;
    logic [7:0] result;

    fp8_dot_if src_if ();

    fp8_dot_sequencer #(.LEN_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .len         (len),
        .src         (src_if),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sum     (add_sum),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp8_to_real(input logic [7:0] v);
        int  e;
        int  m;
        real mag;
        e = int'(v[6:3]);
        m = int'(v[2:0]);
        if (e == 0) mag = real'(m) * pow2(-9);
        else        mag = (1.0 + real'(m) / 8.0) * pow2(e - 7);
        return v[7] ? -mag : mag;
    endfunction

    function automatic logic [7:0] real_to_fp8(input real x);
        logic s;
        real  mag;
        int   e;
        int   m;
        s   = (x < 0.0);
        mag = s ? -x : x;
        if (mag == 0.0) return 8'h00;
        if (mag >= 448.0) return {s, 7'h7E};
        if (mag < pow2(-6)) begin
            m = $rtoi(mag / pow2(-9) + 0.5);
            if (m >= 8) return {s, 4'd1, 3'd0};
            return {s, 4'd0, 3'(m)};
        end
        e = -6;
        while (mag >= pow2(e + 1)) e++;
        m = $rtoi((mag / pow2(e) - 1.0) * 8.0 + 0.5);
        if (m == 8) begin
            e++;
            m = 0;
        end
        if ((e + 7 > 15) || ((e + 7 == 15) && (m == 7))) return {s, 7'h7E};
        return {s, 4'(e + 7), 3'(m)};
    endfunction

    function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
        return real_to_fp8(fp8_to_real(a) * fp8_to_real(b));
    endfunction

    function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b);
        return real_to_fp8(fp8_to_real(a) + fp8_to_real(b));
    endfunction

    // External combinational datapath seen by the sequencer
    always_comb mul_product = fp8_mul(mul_a, mul_b);
    always_comb add_sum     = fp8_add(add_a, add_b);

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: job-level view (busy, accepting, pairs left, expected done cycle)
    int         cyc = 0;
    int         exp_done_at = -1;
    int         m_left = 0;
    logic       m_busy = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_last = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check1("rst_in_ready", src_if.in_ready, 1'b0);
            check1("rst_busy", busy, 1'b0);
            check1("rst_done", done, 1'b0);
            check8("rst_result", result, 8'h00);
            check8("rst_mul_a", mul_a, 8'h00);
            check8("rst_add_b", add_b, 8'h00);
            m_busy      = 1'b0;
            m_ready     = 1'b0;
            exp_done_at = -1;
            m_last      = 8'h00;
        end else begin
            check1("in_ready", src_if.in_ready, m_ready);
            check1("busy", busy, m_busy);
            check1("done", done, cyc == exp_done_at);
            if (cyc == exp_done_at)  check8("result_at_done", result, m_acc);
            else if (!m_busy)        check8("result_hold", result, m_last);

            if (cyc == exp_done_at) begin
                m_busy = 1'b0;
                m_last = m_acc;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_acc  = 8'h00;
                    m_left = int'(len);
                    if (len == 8'd0) exp_done_at = cyc + 1;
                    else             m_ready = 1'b1;
                end
            end else if (m_ready && src_if.in_valid) begin
                m_acc = fp8_add(m_acc, fp8_mul(src_if.in_a, src_if.in_b));
                m_left--;
                if (m_left == 0) begin
                    m_ready     = 1'b0;
                    exp_done_at = cyc + 3;
                end
            end
        end
    end

    logic [7:0] job_a [16];
    logic [7:0] job_b [16];

    // gap < 0: random bubbles; poke: pulse start/len=5 mid-run; abort: reset right after last handshake
    task automatic run_job(input int n, input int gap, input bit poke, input bit abort,
                           output logic [7:0] res);
        int   t;
        int   g;
        logic hs;
        res = 8'hxx;
        @(posedge clk); #1;
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            src_if.in_valid = 1'b1;
            src_if.in_a     = job_a[i];
            src_if.in_b     = job_b[i];
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 50) begin
                @(negedge clk);
                hs = src_if.in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!hs) begin
                n_cmp++;
                n_bad++;
                $display("FAIL handshake_timeout: pair %0d not accepted within 50 cycles", i);
            end
            src_if.in_valid = 1'b0;
            src_if.in_a     = 8'($urandom);
            src_if.in_b     = 8'($urandom);
            if (poke && i == 0) begin
                start = 1'b1;
                len   = 8'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (i < n - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                for (int k = 0; k < g; k++) begin
                    @(posedge clk); #1;
                end
            end
        end
        if (abort) begin
            rst_n = 1'b0;
            #1;
            check1("abort_busy", busy, 1'b0);
            check1("abort_done", done, 1'b0);
            check8("abort_result", result, 8'h00);
            check8("abort_mul_a", mul_a, 8'h00);
            check8("abort_add_a", add_a, 8'h00);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        t = 0;
        hs = 1'b0;
        while (!hs && t < 20) begin
            @(negedge clk);
            hs = done;
            t++;
        end
        if (hs) res = result;
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within 20 cycles of last pair");
        end
    endtask

    logic [7:0] r;

    initial begin
        src_if.in_valid = 1'b0;
        src_if.in_a     = 8'h00;
        src_if.in_b     = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check8("pin_mul_38_3c", fp8_mul(8'h38, 8'h3C), 8'h3C);
        check8("pin_mul_3c_3c", fp8_mul(8'h3C, 8'h3C), 8'h41);
        check8("pin_add_3c_41", fp8_add(8'h3C, 8'h41), 8'h47);
        check8("pin_mul_40_c6", fp8_mul(8'h40, 8'hC6), 8'hCE);
        check8("pin_add_ce_4e", fp8_add(8'hCE, 8'h4E), 8'h00);

        job_a[0] = 8'h38; job_b[0] = 8'h3C;
        job_a[1] = 8'h3C; job_b[1] = 8'h3C;
        run_job(2, 0, 1'b0, 1'b0, r);
        check8("sum_of_products", r, 8'h47);

        run_job(0, 0, 1'b0, 1'b0, r);
        check8("zero_length", r, 8'h00);

        job_a[0] = 8'h40; job_b[0] = 8'hC6;
        job_a[1] = 8'hC0; job_b[1] = 8'hC6;
        job_a[2] = 8'h00; job_b[2] = 8'h46;
        run_job(3, 2, 1'b0, 1'b0, r);
        check8("bubbles", r, 8'h00);

        job_a[0] = 8'h38; job_b[0] = 8'h3C;
        job_a[1] = 8'h3C; job_b[1] = 8'h3C;
        run_job(2, 1, 1'b1, 1'b0, r);
        check8("start_while_busy", r, 8'h47);

        run_job(2, 0, 1'b0, 1'b1, r);
        job_a[0] = 8'h40; job_b[0] = 8'h40;
        run_job(1, 0, 1'b0, 1'b0, r);
        check8("after_reset_job", r, 8'h48);

        job_a[0] = 8'h3C; job_b[0] = 8'h38;
        run_job(1, 0, 1'b0, 1'b0, r);
        check8("back_to_back", r, 8'h3C);

        for (int j = 0; j < 30; j++) begin
            int n;
            n = int'($urandom_range(0, 9));
            for (int i = 0; i < n; i++) begin
                job_a[i] = 8'($urandom);
                job_b[i] = 8'($urandom);
            end
            run_job(n, -1, ($urandom_range(0, 3) == 0), 1'b0, r);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
